// File: rtl/dot_clock_pkg.sv
// Shared constants and width helpers for the dot clock generator.
package dot_clock_pkg;

  localparam int DIV_DEFAULT         = 2;
  localparam int LOCK_CYCLES_DEFAULT = 4;
  localparam int LOCK_W              = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int cnt_width(input int div);
    return (clog2(div) < 1) ? 1 : clog2(div);
  endfunction

endpackage

// File: rtl/dot_clock_gen_rst_sync.sv
// Two-flop reset synchroniser: asynchronous assert, release on the 2nd clk rising edge.
// Fixed 2-cycle release latency; no flow control.
module rst_sync (
  input  logic clk,
  input  logic rst_n,
  output logic rst_s
);

  logic ff1;
  logic ff2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1 <= 1'b0;
      ff2 <= 1'b0;
    end else begin
      ff1 <= 1'b1;
      ff2 <= ff1;
    end
  end

  assign rst_s = ff2;

endmodule

// File: rtl/dot_clock_gen.sv
// Integer divider producing the VGA dot clock, a board-domain enable strobe and a lock flag.
// First period starts 3 board edges after reset release; free-running, no backpressure.
import dot_clock_pkg::*;

module dot_clock_gen #(
  parameter int DIV         = DIV_DEFAULT,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEFAULT
) (
  input  logic board,
  input  logic rst_n,
  output logic dotclock,
  output logic dot_en,
  output logic locked
);

  localparam int CNT_W = cnt_width(DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DIV - 1);
  localparam logic [LOCK_W-1:0] LOCK_TGT = LOCK_W'(LOCK_CYCLES);

  logic              rst_s;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              wrap;
  logic [LOCK_W-1:0] pcnt;

  rst_sync u_rst_sync (
    .clk   (board),
    .rst_n (rst_n),
    .rst_s (rst_s)
  );

  assign cnt_next = (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
  assign wrap     = (cnt_next == '0);

  always_ff @(posedge board or negedge rst_s) begin
    if (!rst_s) begin
      cnt    <= CNT_MAX;
      dot_en <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      dot_en <= wrap;
    end
  end

  // Period counter saturates so that large LOCK_CYCLES never roll the flag back.
  always_ff @(posedge board or negedge rst_s) begin
    if (!rst_s) begin
      pcnt   <= '0;
      locked <= 1'b0;
    end else if (wrap) begin
      if (pcnt != '1) pcnt <= pcnt + 1'b1;
      if (pcnt == LOCK_TGT) locked <= 1'b1;
    end
  end

  generate
    if (DIV == 1) begin : g_div1
      logic run;
      // Enabling on the falling edge keeps the gated clock free of runt pulses.
      always_ff @(negedge board or negedge rst_s) begin
        if (!rst_s) run <= 1'b0;
        else        run <= 1'b1;
      end
      assign dotclock = board & run;
    end else if ((DIV % 2) == 0) begin : g_even
      logic dclk;
      always_ff @(posedge board or negedge rst_s) begin
        if (!rst_s) dclk <= 1'b0;
        else        dclk <= (cnt_next < CNT_W'(DIV / 2));
      end
      assign dotclock = dclk;
    end else begin : g_odd
      logic p;
      logic n;
      always_ff @(posedge board or negedge rst_s) begin
        if (!rst_s) p <= 1'b0;
        else        p <= (cnt_next < CNT_W'((DIV + 1) / 2));
      end
      // Half-cycle delayed copy trims the high time to exactly DIV/2 board cycles.
      always_ff @(negedge board or negedge rst_s) begin
        if (!rst_s) n <= 1'b0;
        else        n <= p;
      end
      assign dotclock = p & n;
    end
  endgenerate

endmodule

// File: tb/tb_dot_clock_gen.sv
// Directed bench for dot_clock_gen covering even, odd, unity and maximum divide ratios.
module tb_dot_clock_gen;

  logic board;
  logic rst_n;

  logic clk2, en2, lk2;
  logic clk5, en5, lk5;
  logic clk1, en1, lk1;
  logic clk4, en4, lk4;
  logic clk256, en256, lk256;

  int n_cmp;
  int n_bad;
  int pulses4;

  dot_clock_gen #(.DIV(2),   .LOCK_CYCLES(4)) u_d2   (.board(board), .rst_n(rst_n), .dotclock(clk2),   .dot_en(en2),   .locked(lk2));
  dot_clock_gen #(.DIV(5),   .LOCK_CYCLES(4)) u_d5   (.board(board), .rst_n(rst_n), .dotclock(clk5),   .dot_en(en5),   .locked(lk5));
  dot_clock_gen #(.DIV(1),   .LOCK_CYCLES(4)) u_d1   (.board(board), .rst_n(rst_n), .dotclock(clk1),   .dot_en(en1),   .locked(lk1));
  dot_clock_gen #(.DIV(4),   .LOCK_CYCLES(4)) u_d4   (.board(board), .rst_n(rst_n), .dotclock(clk4),   .dot_en(en4),   .locked(lk4));
  dot_clock_gen #(.DIV(256), .LOCK_CYCLES(1)) u_d256 (.board(board), .rst_n(rst_n), .dotclock(clk256), .dot_en(en256), .locked(lk256));

  initial board = 1'b0;
  always #5 board = ~board;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // k counts board rising edges since rst_n release; ph 0 = high phase, 1 = low phase.
  function automatic logic exp_clk(input int div, input int k, input int ph);
    int m;
    if (k < 3) return 1'b0;
    m = (k - 3) % div;
    if (div == 1) return (ph == 0);
    if ((div % 2) == 0) return (m < div / 2);
    if (ph == 1) return (m < (div + 1) / 2);
    return (m >= 1) && (m < (div + 1) / 2);
  endfunction

  function automatic logic exp_en(input int div, input int k);
    if (k < 3) return 1'b0;
    return ((k - 3) % div) == 0;
  endfunction

  function automatic logic exp_lock(input int div, input int lc, input int k);
    return k >= 3 + lc * div;
  endfunction

  task automatic check_all(input int k, input int ph);
    string s;
    s = $sformatf("k%0d.p%0d", k, ph);
    chk({"clk2.", s},   32'(clk2),   32'(exp_clk(2, k, ph)));
    chk({"clk5.", s},   32'(clk5),   32'(exp_clk(5, k, ph)));
    chk({"clk1.", s},   32'(clk1),   32'(exp_clk(1, k, ph)));
    chk({"clk4.", s},   32'(clk4),   32'(exp_clk(4, k, ph)));
    chk({"clk256.", s}, 32'(clk256), 32'(exp_clk(256, k, ph)));
    chk({"en2.", s},    32'(en2),    32'(exp_en(2, k)));
    chk({"en5.", s},    32'(en5),    32'(exp_en(5, k)));
    chk({"en1.", s},    32'(en1),    32'(exp_en(1, k)));
    chk({"en4.", s},    32'(en4),    32'(exp_en(4, k)));
    chk({"en256.", s},  32'(en256),  32'(exp_en(256, k)));
    chk({"lk2.", s},    32'(lk2),    32'(exp_lock(2, 4, k)));
    chk({"lk5.", s},    32'(lk5),    32'(exp_lock(5, 4, k)));
    chk({"lk1.", s},    32'(lk1),    32'(exp_lock(1, 4, k)));
    chk({"lk4.", s},    32'(lk4),    32'(exp_lock(4, 4, k)));
    chk({"lk256.", s},  32'(lk256),  32'(exp_lock(256, 1, k)));
  endtask

  task automatic release_and_run(input int n);
    @(negedge board);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(posedge board);
      #1;
      check_all(k, 0);
      if (k >= 20 && k < 120 && en4 === 1'b1) pulses4 = pulses4 + 1;
      if (k == 2)   chk("cnt256.rst",  32'(u_d256.cnt), 32'd255);
      if (k == 258) chk("cnt256.top",  32'(u_d256.cnt), 32'd255);
      if (k == 259) chk("cnt256.wrap", 32'(u_d256.cnt), 32'd0);
      @(negedge board);
      #1;
      check_all(k, 1);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    pulses4 = 0;
    rst_n   = 1'b0;

    // Held in reset: everything quiet, including the gated unity clock while board is high.
    for (int i = 0; i < 4; i++) begin
      @(posedge board);
      #1;
      chk("rst.clk1", 32'(clk1), 32'd0);
      chk("rst.clk2", 32'(clk2), 32'd0);
      chk("rst.clk5", 32'(clk5), 32'd0);
      chk("rst.en4",  32'(en4),  32'd0);
      chk("rst.lk4",  32'(lk4),  32'd0);
    end

    release_and_run(600);
    chk("pulses4", 32'(pulses4), 32'd25);

    // Reset mid-operation while dotclock of DIV=2/4 is high, with no board edge.
    while (!(clk4 === 1'b1 && clk2 === 1'b1 && ((u_d4.cnt) == 2'd0))) begin
      @(posedge board);
      #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("mid.clk2", 32'(clk2), 32'd0);
    chk("mid.clk4", 32'(clk4), 32'd0);
    chk("mid.clk1", 32'(clk1), 32'd0);
    chk("mid.en2",  32'(en2),  32'd0);
    chk("mid.en1",  32'(en1),  32'd0);
    chk("mid.lk4",  32'(lk4),  32'd0);
    chk("mid.lk1",  32'(lk1),  32'd0);
    chk("mid.lk256", 32'(lk256), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge board);
      #1;
      chk("hold.clk1", 32'(clk1), 32'd0);
      chk("hold.clk5", 32'(clk5), 32'd0);
    end

    release_and_run(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
